fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch front end. Walks a fetch pointer through instruction
// memory one word (4 bytes) at a time. Returned words are buffered with their
// fetch address in a 2-entry FIFO that feeds decode. Branch/jump redirects
// flush the FIFO and retarget the fetch pointer. If a request is still
// outstanding when a redirect arrives, its data is drained and dropped.
//
// Ports
//   clk, rst        : clock; asynchronous active-high reset
//   redirect_valid  : redirect request this cycle
//   redirect_pc     : redirect target
//   pc_load         : program counter load enable
//   pc_next         : value loaded into the program counter
//   imem_req        : instruction memory request
//   imem_addr       : instruction memory request address (the addr_q register)
//   imem_ack        : memory acknowledge; imem_rdata is valid in the same cycle
//   imem_rdata      : returned instruction word
//   inst_valid      : the FIFO head is valid
//   inst_data       : instruction word at the FIFO head
//   inst_pc         : fetch address of the FIFO head
//   inst_ready      : decode accepts the head this cycle
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready
);

  typedef enum logic [1:0] {IDLE, REQ, STALL, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt, addr_inc;
  logic [ADDR_WIDTH-1:0]   fifo_pc   [2];
  logic [DATA_WIDTH-1:0]   fifo_data [2];
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              count, count_nxt;
  logic                    push, pop;

  assign addr_inc   = addr_q + ADDR_WIDTH'(4);
  assign imem_req   = (state == REQ) || (state == DRAIN);
  assign imem_addr  = addr_q;
  assign inst_valid = (count != 2'd0);
  assign inst_data  = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // A redirect overrides everything else. The ack data is dropped and any
  // pop in the same cycle is lost, because the FIFO is flushed anyway.
  // Acks are only accepted while a request is actually outstanding.
  assign push = (state == REQ) && imem_ack && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    if (redirect_valid)
      count_nxt = 2'd0;
    else
      count_nxt = count + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    fetch_pc_nxt = fetch_pc;
    pc_load      = 1'b0;
    pc_next      = '0;

    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc;
      pc_load      = 1'b1;
      pc_next      = redirect_pc;
    end else if (push) begin
      fetch_pc_nxt = addr_inc;
      pc_load      = 1'b1;
      pc_next      = addr_inc;
    end

    case (state)
      IDLE: begin
        state_nxt = REQ;
        addr_nxt  = redirect_valid ? redirect_pc : fetch_pc;
      end
      REQ: begin
        if (redirect_valid) begin
          // Without an ack the request stays on the bus until memory
          // answers. Its data is then drained and dropped.
          if (imem_ack) begin
            state_nxt = REQ;
            addr_nxt  = redirect_pc;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (imem_ack) begin
          addr_nxt  = addr_inc;
          state_nxt = (count_nxt == 2'd2) ? STALL : REQ;
        end
      end
      STALL: begin
        // The next request reuses addr_q, which already equals fetch_pc.
        if (redirect_valid) begin
          state_nxt = REQ;
          addr_nxt  = redirect_pc;
        end else if (count_nxt != 2'd2) begin
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_nxt = REQ;
          addr_nxt  = redirect_valid ? redirect_pc : fetch_pc;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      pc_load = 1'b0;
      pc_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      addr_q   <= addr_nxt;
      count    <= count_nxt;
      if (redirect_valid) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]   <= addr_q;
          fifo_data[wr_ptr] <= imem_rdata;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_load(pc_load), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Inputs change 1 time unit after the rising edge, and checks run 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h55; imem_ack = 1'b1; imem_rdata = 32'h1234;
    tick(); settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("[TB] FAIL rst_pc_load: got %b want 0", pc_load); end
    checks++; if (pc_next !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc_next: got %h want 0", pc_next); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", inst_valid); end
    checks++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst: got %h/%h want 0/0", inst_data, inst_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h want 0", imem_addr); end
    do_reset();
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stream_idle_req: got %b want 0", imem_req); end
    tick();
    imem_rdata = word_for(32'h0);
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL stream_first_req: got %b/%h want 1/0", imem_req, imem_addr); end
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h4) begin errors++; $display("[TB] FAIL stream_first_pc: got %b/%h want 1/4", pc_load, pc_next); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_no_bypass: got %b want 0", inst_valid); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      a = 32'(4 * k);
      imem_rdata = word_for(a);
      settle();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== a - 32'h4) begin errors++; $display("[TB] FAIL stream_head_%0d: got %b/%h want 1/%h", k, inst_valid, inst_pc, a - 32'h4); end
      checks++; if (inst_data !== word_for(a - 32'h4)) begin errors++; $display("[TB] FAIL stream_data_%0d: got %h want %h", k, inst_data, word_for(a - 32'h4)); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("[TB] FAIL stream_addr_%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, a); end
      checks++; if (pc_load !== 1'b1 || pc_next !== a + 32'h4) begin errors++; $display("[TB] FAIL stream_pc_%0d: got %b/%h want 1/%h", k, pc_load, pc_next, a + 32'h4); end
    end
    imem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b0;
    tick(); imem_rdata = word_for(32'h0);
    tick(); imem_rdata = word_for(32'h4);
    tick(); imem_ack = 1'b0; settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b want 0", imem_req); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("[TB] FAIL stall_pc_load: got %b want 0", pc_load); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL stall_head: got %b/%h want 1/0", inst_valid, inst_pc); end
    tick(); settle();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL stall_hold: got %b/%h want 0/8", imem_req, imem_addr); end
    inst_ready = 1'b1;
    tick(); inst_ready = 1'b0; settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL stall_resume: got %b/%h want 1/8", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== word_for(32'h4)) begin errors++; $display("[TB] FAIL stall_second: got %b/%h/%h want 1/4/%h", inst_valid, inst_pc, inst_data, word_for(32'h4)); end
  endtask

  task automatic test_drain();
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    tick(); imem_rdata = word_for(32'h0);
    tick(); imem_rdata = word_for(32'h4);
    tick(); imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100; settle();
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h100) begin errors++; $display("[TB] FAIL drain_redirect_pc: got %b/%h want 1/100", pc_load, pc_next); end
    tick(); redirect_valid = 1'b0; settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_flush: got %b want 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL drain_hold: got %b/%h want 1/8", imem_req, imem_addr); end
    tick(); settle();
    checks++; if (pc_load !== 1'b0) begin errors++; $display("[TB] FAIL drain_idle_load: got %b want 0", pc_load); end
    tick(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
    checks++; if (pc_load !== 1'b0) begin errors++; $display("[TB] FAIL drain_ack_load: got %b want 0", pc_load); end
    tick(); imem_ack = 1'b0; settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL drain_next_addr: got %b/%h want 1/100", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_discard: got %b want 0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_ack();
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    tick(); imem_rdata = word_for(32'h0);
    tick(); imem_rdata = word_for(32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h200; settle();
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h200) begin errors++; $display("[TB] FAIL rack_pc: got %b/%h want 1/200", pc_load, pc_next); end
    tick(); redirect_valid = 1'b0; imem_ack = 1'b0; settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rack_flush: got %b want 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL rack_addr: got %b/%h want 1/200", imem_req, imem_addr); end
    tick(); settle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rack_no_push: got %b want 0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_idle_redirect: got %b/%h want 1/fffffffc", pc_load, pc_next); end
    tick(); redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D; settle();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", imem_addr); end
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc_next: got %b/%h want 1/0", pc_load, pc_next); end
    tick(); imem_ack = 1'b0; settle();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next_addr: got %h want 0", imem_addr); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL wrap_head: got %b/%h/%h want 1/fffffffc/0badf00d", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick();
    rst = 1'b1; settle();
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_async: got %b/%b want 0/0", imem_req, inst_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777; inst_ready = 1'b1;
    tick(); settle();
    checks++; if (pc_load !== 1'b0 || pc_next !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rmid_hold: got %b/%h/%h want 0/0/0", pc_load, pc_next, imem_addr); end
    rst = 1'b0; settle();
    checks++; if (pc_load !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rmid_post_ack: got %b/%b want 0/0", pc_load, imem_req); end
    tick(); imem_ack = 1'b0; settle();
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rmid_no_inst: got %b/%h want 0/0", inst_valid, imem_addr); end
    inst_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_drain();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
